// File: rtl/wdata_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module   : wdata_fifo_mc
// Purpose  : Multi-channel write-data FIFO. There is one independent queue per
//            bank/channel. Write data arrives tagged with a channel ID. The
//            scheduler pops the head of the channel it issues a WRITE to.
//            All DEPTH entries of a queue are usable. The block also provides
//            fill counts, a per-channel flush and sticky overflow/underflow
//            flags.
// Ports    : clk, rst_n (synchronous, active-low)
//            wr_en/wr_ch/wr_data      - push into channel wr_ch
//            rd_en/rd_ch -> rd_data   - pop channel rd_ch; rd_data shows its
//                                       head with first-word fall-through
//            flush_en/flush_ch        - empty channel flush_ch
//            empty/full/virtual_full  - per-channel status
//            count                    - per-channel fill level, AW+1 bits each
//            ovf_err/udf_err/parity_err - sticky error flags
// Options  : define WDATA_FIFO_PARITY_EN to store an even-parity bit with each
//            entry and check it on every accepted read. Without it,
//            parity_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module wdata_fifo_mc #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 32,
    parameter int NUM_CH   = 4,
    parameter int AFULL_TH = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [CW-1:0]            wr_ch,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [CW-1:0]            rd_ch,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     flush_en,
    input  logic [CW-1:0]            flush_ch,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        virtual_full,
    output logic [NUM_CH*(AW+1)-1:0] count,
    output logic                     ovf_err,
    output logic                     udf_err,
    output logic                     parity_err
);

    localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_afull_th = (AW+1)'(AFULL_TH);

    logic [DATA_W-1:0] w_head [NUM_CH];
    logic [NUM_CH-1:0] w_wr_acc;
    logic [NUM_CH-1:0] w_rd_acc;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_udf;
`ifdef WDATA_FIFO_PARITY_EN
    logic [NUM_CH-1:0] w_par_bad;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [CW-1:0] c_id = CW'(c);

        logic [AW:0]       r_wr_ptr;
        logic [AW:0]       r_rd_ptr;
        logic [AW:0]       w_cnt;
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic              w_fl_sel;
        logic              w_wr_sel;
        logic              w_rd_sel;

        // A flush to this channel masks any same-cycle read or write to it.
        // The masked operation is not an error.
        assign w_fl_sel = flush_en && (flush_ch == c_id);
        assign w_wr_sel = wr_en && (wr_ch == c_id) && !w_fl_sel;
        assign w_rd_sel = rd_en && (rd_ch == c_id) && !w_fl_sel;

        // The wrap bit lets the subtraction tell a full queue from an empty one.
        assign w_cnt           = r_wr_ptr - r_rd_ptr;
        assign empty[c]        = (w_cnt == '0);
        assign full[c]         = (w_cnt == c_depth);
        assign virtual_full[c] = ((c_depth - w_cnt) < c_afull_th);
        assign count[c*(AW+1) +: AW+1] = w_cnt;

        // Accept or reject is decided on the pre-edge occupancy. A same-cycle
        // read never frees room for the write, and a same-cycle write never
        // feeds the read.
        assign w_wr_acc[c] = w_wr_sel && !full[c];
        assign w_ovf[c]    = w_wr_sel && full[c];
        assign w_rd_acc[c] = w_rd_sel && !empty[c];
        assign w_udf[c]    = w_rd_sel && empty[c];

        assign w_head[c] = r_mem[r_rd_ptr[AW-1:0]];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else if (w_fl_sel) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_wr_acc[c]) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (w_rd_acc[c]) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n && w_wr_acc[c]) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end

`ifdef WDATA_FIFO_PARITY_EN
        logic r_par [DEPTH];

        always_ff @(posedge clk) begin
            if (rst_n && w_wr_acc[c]) r_par[r_wr_ptr[AW-1:0]] <= ^wr_data;
        end

        assign w_par_bad[c] = w_rd_acc[c] && (r_par[r_rd_ptr[AW-1:0]] != (^w_head[c]));
`endif
    end

    // Head of the selected channel. The output is zero when that channel is
    // empty, or when rd_ch does not name an existing channel.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((rd_ch == CW'(c)) && !empty[c]) rd_data = w_head[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (|w_ovf) ovf_err <= 1'b1;
            if (|w_udf) udf_err <= 1'b1;
        end
    end

`ifdef WDATA_FIFO_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)          parity_err <= 1'b0;
        else if (|w_par_bad) parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wdata_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdata_fifo_mc
// Purpose  : Self-checking bench for wdata_fifo_mc. A queue-based reference
//            model is stepped every cycle. Directed scenarios are followed by
//            a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdata_fifo_mc;

    localparam int DATA_W   = 128;
    localparam int DEPTH    = 32;
    localparam int NUM_CH   = 4;
    localparam int AFULL_TH = 2;
    localparam int AW       = 5;
    localparam int CW       = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     wr_en;
    logic [CW-1:0]            wr_ch;
    logic [DATA_W-1:0]        wr_data;
    logic                     rd_en;
    logic [CW-1:0]            rd_ch;
    logic [DATA_W-1:0]        rd_data;
    logic                     flush_en;
    logic [CW-1:0]            flush_ch;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        virtual_full;
    logic [NUM_CH*(AW+1)-1:0] count;
    logic                     ovf_err;
    logic                     udf_err;
    logic                     parity_err;

    wdata_fifo_mc #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NUM_CH  (NUM_CH),
        .AFULL_TH(AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .flush_en    (flush_en),
        .flush_ch    (flush_ch),
        .empty       (empty),
        .full        (full),
        .virtual_full(virtual_full),
        .count       (count),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per channel plus the sticky flags.
    logic [DATA_W-1:0] mq [NUM_CH][$];
    bit                m_ovf;
    bit                m_udf;
    bit                m_par;

    int n_cmp;
    int n_mis;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compare every DUT output against the model for the current inputs.
    task automatic check_all();
        logic [DATA_W-1:0] exp_rd;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("count%0d", c), count[c*(AW+1) +: AW+1], mq[c].size());
            chk($sformatf("empty%0d", c), empty[c], mq[c].size() == 0);
            chk($sformatf("full%0d", c), full[c], mq[c].size() == DEPTH);
            chk($sformatf("vfull%0d", c), virtual_full[c], (DEPTH - mq[c].size()) < AFULL_TH);
        end
        exp_rd = (mq[rd_ch].size() != 0) ? mq[rd_ch][0] : '0;
        chk("rd_data", rd_data, exp_rd);
        chk("ovf_err", ovf_err, m_ovf);
        chk("udf_err", udf_err, m_udf);
        chk("parity_err", parity_err, m_par);
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance model.
    task automatic step(input bit we, input int wc, input logic [DATA_W-1:0] wd,
                        input bit re, input int rc,
                        input bit fe, input int fc, input bit rn);
        int sw;
        int sr;
        bit do_w;
        bit do_r;
        wr_en    = we;
        wr_ch    = wc[CW-1:0];
        wr_data  = wd;
        rd_en    = re;
        rd_ch    = rc[CW-1:0];
        flush_en = fe;
        flush_ch = fc[CW-1:0];
        rst_n    = rn;
        @(negedge clk);
        check_all();
        if (!rn) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            m_ovf = 0;
            m_udf = 0;
            m_par = 0;
        end else begin
            sw   = mq[wc].size();
            sr   = mq[rc].size();
            do_w = we && !(fe && fc == wc);
            do_r = re && !(fe && fc == rc);
            if (fe) mq[fc].delete();
            if (do_w) begin
                if (sw == DEPTH) m_ovf = 1;
                else             mq[wc].push_back(wd);
            end
            if (do_r) begin
                if (sr == 0) m_udf = 1;
                else         void'(mq[rc].pop_front());
            end
        end
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        flush_en = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_ch    = '0;
        flush_en = 1'b0;
        flush_ch = '0;
        m_ovf    = 0;
        m_udf    = 0;
        m_par    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", count, '0);
        chk("rst_empty", empty, 4'b1111);
        chk("rst_full", full, '0);
        chk("rst_vfull", virtual_full, '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_errs", {ovf_err, udf_err, parity_err}, '0);

        // Three words into ch0, read back in order
        for (int i = 0; i < 3; i++) step(1, 0, 128'hA5 + i, 0, 0, 0, 0, 1);
        chk("t1_count0", count[AW:0], 3);
        chk("t1_empty", empty, 4'b1110);
        rd_ch = '0;
        #1;
        chk("t1_head", rd_data, 128'hA5);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0, 0, 0, 1);
        chk("t1_empty0", empty[0], 1'b1);

        // Fill ch1 to full, overflow, then drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, rnd_word(), 0, 1, 0, 0, 1);
            if (i == DEPTH - 3) chk("t2_vf_at30", virtual_full[1], 1'b0);
            if (i == DEPTH - 2) chk("t2_vf_at31", virtual_full[1], 1'b1);
        end
        chk("t2_full1", full[1], 1'b1);
        step(1, 1, rnd_word(), 0, 1, 0, 0, 1);
        chk("t2_ovf", ovf_err, 1'b1);
        chk("t2_count1", count[2*(AW+1)-1 -: AW+1], DEPTH);
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 1, 1, 0, 0, 1);
        chk("t2_empty1", empty[1], 1'b1);

        // Wrap on ch2 with concurrent push/pop
        do_reset();
        step(1, 2, rnd_word(), 0, 2, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 2, rnd_word(), 1, 2, 0, 0, 1);
        chk("t3_count2", count[3*(AW+1)-1 -: AW+1], 1);
        step(0, 2, '0, 1, 2, 0, 0, 1);

        // Underflow on ch3 with a same-cycle write
        do_reset();
        rd_ch = 2'd3;
        #1;
        chk("t4_rd_empty", rd_data, '0);
        step(1, 3, 128'h1234_5678, 1, 3, 0, 0, 1);
        chk("t4_udf", udf_err, 1'b1);
        chk("t4_count3", count[4*(AW+1)-1 -: AW+1], 1);

        // Flush ch0 with colliding write/read, ch1 untouched
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, rnd_word(), 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, rnd_word(), 0, 1, 0, 0, 1);
        step(1, 0, rnd_word(), 1, 0, 1, 0, 1);
        chk("t5_count0", count[AW:0], 0);
        chk("t5_errs", {ovf_err, udf_err}, 2'b00);
        chk("t5_count1", count[2*(AW+1)-1 -: AW+1], 3);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1, 0, 0, 1);

`ifdef WDATA_FIFO_PARITY_EN
        // Corrupt a stored parity bit, then read the entry
        do_reset();
        step(1, 0, rnd_word(), 0, 0, 0, 0, 1);
        dut.g_ch[0].r_par[0] = ~dut.g_ch[0].r_par[0];
        step(0, 0, '0, 1, 0, 0, 0, 1);
        m_par = 1;
        chk("t6_parity", parity_err, 1'b1);
`endif

        // Randomized traffic: alternating write-heavy and read-heavy phases
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit heavy_w;
            heavy_w = ((i / 400) % 2) == 0;
            step($urandom_range(0, 99) < (heavy_w ? 75 : 35),
                 $urandom_range(0, NUM_CH - 1), rnd_word(),
                 $urandom_range(0, 99) < (heavy_w ? 35 : 75),
                 $urandom_range(0, NUM_CH - 1),
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, NUM_CH - 1),
                 !($urandom_range(0, 999) < 3));
        end
        @(negedge clk);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
